// File: rtl/free_list_ctrl.sv
// Rename-stage physical register free list with branch checkpoints for mispredict recovery.
// Optional macro FREELIST_BYPASS_EN: when the list is empty, a same-cycle release is handed straight to the allocator.
module free_list_ctrl #(
  parameter int PHYS_REGS  = 64,
  parameter int ARCH_REGS  = 32,
  parameter int CKPT_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 alloc_req,
  output logic                                 alloc_gnt,
  output logic [$clog2(PHYS_REGS)-1:0]         alloc_preg,
  input  logic                                 free_valid,
  input  logic [$clog2(PHYS_REGS)-1:0]         free_preg,
  input  logic                                 ckpt_req,
  output logic                                 ckpt_ack,
  output logic [$clog2(CKPT_DEPTH)-1:0]        ckpt_id,
  output logic                                 ckpt_full,
  input  logic                                 ckpt_release,
  input  logic                                 flush,
  output logic [$clog2(PHYS_REGS-ARCH_REGS):0] free_count,
  output logic                                 ovf_err
);

  localparam int PW       = $clog2(PHYS_REGS);
  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int IW       = $clog2(FL_DEPTH);
  localparam int CW       = $clog2(CKPT_DEPTH);
  localparam int OW       = $clog2(CKPT_DEPTH + 1);

  logic [PW-1:0] fifo [FL_DEPTH];
  logic [IW:0]   slot [CKPT_DEPTH];
  logic [IW:0]   head, tail, head_nxt, count;
  logic [CW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;
  logic          empty, full, pop, push, bypass, ckpt_take, ckpt_drop;

  always_comb begin
    count  = tail - head;
    empty  = (count == '0);
    full   = (count == (IW+1)'(FL_DEPTH));
    bypass = 1'b0;
`ifdef FREELIST_BYPASS_EN
    bypass = rst_n & empty & alloc_req & free_valid & ~flush;
`endif
    // A mispredict squashes this cycle's allocation regardless of checkpoint state.
    pop        = rst_n & alloc_req & ~empty & ~flush;
    alloc_gnt  = pop | bypass;
    alloc_preg = bypass ? free_preg : fifo[head[IW-1:0]];
    push       = free_valid & (~full | pop) & ~bypass;
    head_nxt   = head + (IW+1)'(pop);
    ckpt_full  = (occ == OW'(CKPT_DEPTH));
    ckpt_take  = rst_n & ckpt_req & ~ckpt_full & ~flush;
    ckpt_drop  = ckpt_release & (occ != '0);
    ckpt_ack   = ckpt_take;
    ckpt_id    = wr_ptr;
    free_count = count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) fifo[i] <= PW'(ARCH_REGS + i);
    end else if (push) begin
      fifo[tail[IW-1:0]] <= free_preg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= (IW+1)'(FL_DEPTH);
      ovf_err <= 1'b0;
    end else begin
      if (flush && occ != '0) head <= slot[rd_ptr];
      else                    head <= head_nxt;
      if (push) tail <= tail + 1'b1;
      if (free_valid && full && !pop) ovf_err <= 1'b1;
    end
  end

  // Slots capture the post-allocation head so a flush rewinds to just after the branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CKPT_DEPTH; i++) slot[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (ckpt_take) begin
        slot[wr_ptr] <= head_nxt;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (ckpt_drop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + OW'(ckpt_take) - OW'(ckpt_drop);
    end
  end

endmodule

// File: tb/tb_free_list_ctrl.sv
// Self-checking bench for free_list_ctrl: vector table plus hand sequences, scoreboard-queued expectations.
module tb_free_list_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_req = 1'b0, free_valid = 1'b0, ckpt_req = 1'b0, ckpt_release = 1'b0, flush = 1'b0;
  logic [5:0] free_preg = '0;
  logic       alloc_gnt, ckpt_ack, ckpt_full, ovf_err;
  logic [5:0] alloc_preg, free_count;
  logic [1:0] ckpt_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       a, f;
    logic [5:0] fp;
    logic       c, r, fl;
    logic       e_gnt;
    logic [5:0] e_preg;
    logic       e_ack;
    logic [1:0] e_id;
    logic       e_full;
    logic [5:0] e_cnt;
    logic       e_ovf;
    string      tag;
  } vec_t;

  vec_t sb_q[$];
  vec_t table_v[24];

  free_list_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_preg(alloc_preg),
    .free_valid(free_valid), .free_preg(free_preg),
    .ckpt_req(ckpt_req), .ckpt_ack(ckpt_ack), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .ckpt_release(ckpt_release), .flush(flush),
    .free_count(free_count), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string tag, logic a, logic f, logic [5:0] fp, logic c, logic r, logic fl,
                              logic g, logic [5:0] p, logic ack, logic [1:0] id, logic full,
                              logic [5:0] cnt, logic ovf);
    vec_t v;
    v.a = a; v.f = f; v.fp = fp; v.c = c; v.r = r; v.fl = fl;
    v.e_gnt = g; v.e_preg = p; v.e_ack = ack; v.e_id = id; v.e_full = full;
    v.e_cnt = cnt; v.e_ovf = ovf; v.tag = tag;
    return v;
  endfunction

  task automatic checkField(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %0d, expected %0d", tag, field, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb_q.pop_front();
      checkField(e.tag, "alloc_gnt",  32'(alloc_gnt),  32'(e.e_gnt));
      checkField(e.tag, "alloc_preg", 32'(alloc_preg), 32'(e.e_preg));
      checkField(e.tag, "ckpt_ack",   32'(ckpt_ack),   32'(e.e_ack));
      checkField(e.tag, "ckpt_id",    32'(ckpt_id),    32'(e.e_id));
      checkField(e.tag, "ckpt_full",  32'(ckpt_full),  32'(e.e_full));
      checkField(e.tag, "free_count", 32'(free_count), 32'(e.e_cnt));
      checkField(e.tag, "ovf_err",    32'(ovf_err),    32'(e.e_ovf));
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare at the falling edge.
  task automatic applyStimulus(input vec_t v);
    alloc_req = v.a; free_valid = v.f; free_preg = v.fp;
    ckpt_req = v.c; ckpt_release = v.r; flush = v.fl;
    sb_q.push_back(v);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    alloc_req = 0; free_valid = 0; free_preg = 0; ckpt_req = 0; ckpt_release = 0; flush = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    //                  tag   a f fp c r fl  gnt preg ack id full cnt ovf
    table_v[0]  = mk("", 0,0,0, 0,0,0,  0,32,0,0,0,32,0);
    table_v[1]  = mk("", 1,0,0, 0,0,0,  1,32,0,0,0,32,0);
    table_v[2]  = mk("", 1,0,0, 0,0,0,  1,33,0,0,0,31,0);
    table_v[3]  = mk("", 1,0,0, 0,0,0,  1,34,0,0,0,30,0);
    table_v[4]  = mk("", 0,0,0, 0,0,0,  0,35,0,0,0,29,0);
    table_v[5]  = mk("", 0,0,0, 1,0,0,  0,35,1,0,0,29,0);
    table_v[6]  = mk("", 1,0,0, 0,0,0,  1,35,0,1,0,29,0);
    table_v[7]  = mk("", 1,0,0, 0,0,0,  1,36,0,1,0,28,0);
    table_v[8]  = mk("", 0,0,0, 0,0,1,  0,37,0,1,0,27,0);
    table_v[9]  = mk("", 1,0,0, 0,0,0,  1,35,0,0,0,29,0);
    table_v[10] = mk("", 1,1,3, 0,0,0,  1,36,0,0,0,28,0);
    table_v[11] = mk("", 0,1,4, 0,0,0,  0,37,0,0,0,28,0);
    table_v[12] = mk("", 0,0,0, 0,1,0,  0,37,0,0,0,29,0);
    table_v[13] = mk("", 1,0,0, 1,0,0,  1,37,1,0,0,29,0);
    table_v[14] = mk("", 0,0,0, 1,0,0,  0,38,1,1,0,28,0);
    table_v[15] = mk("", 0,0,0, 1,1,0,  0,38,1,2,0,28,0);
    table_v[16] = mk("", 0,0,0, 1,0,0,  0,38,1,3,0,28,0);
    table_v[17] = mk("", 0,0,0, 1,0,0,  0,38,1,0,0,28,0);
    table_v[18] = mk("", 0,0,0, 1,0,0,  0,38,0,1,1,28,0);
    table_v[19] = mk("", 0,0,0, 0,1,0,  0,38,0,1,1,28,0);
    table_v[20] = mk("", 1,0,0, 1,0,0,  1,38,1,1,0,28,0);
    table_v[21] = mk("", 1,1,9, 0,0,1,  0,39,0,2,1,27,0);
    table_v[22] = mk("", 0,0,0, 0,0,0,  0,38,0,0,0,29,0);
    table_v[23] = mk("", 1,0,0, 0,0,0,  1,38,0,0,0,29,0);

    // Reset values while requests are asserted during reset.
    alloc_req = 1; ckpt_req = 1; free_valid = 1; free_preg = 5;
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(mk("in_reset", 0,0,0,0,0,0, 0,32,0,0,0,32,0));
    checkOutput();
    doReset();

    for (int i = 0; i < 24; i++) begin
      vec_t v;
      v = table_v[i];
      v.tag = $sformatf("vec%0d", i);
      applyStimulus(v);
    end

    // Checkpoint, three speculative allocs, then rewind.
    doReset();
    applyStimulus(mk("rw_a0", 1,0,0,0,0,0, 1,32,0,0,0,32,0));
    applyStimulus(mk("rw_a1", 1,0,0,0,0,0, 1,33,0,0,0,31,0));
    applyStimulus(mk("rw_ck", 0,0,0,1,0,0, 0,34,1,0,0,30,0));
    applyStimulus(mk("rw_a2", 1,0,0,0,0,0, 1,34,0,1,0,30,0));
    applyStimulus(mk("rw_a3", 1,0,0,0,0,0, 1,35,0,1,0,29,0));
    applyStimulus(mk("rw_a4", 1,0,0,0,0,0, 1,36,0,1,0,28,0));
    applyStimulus(mk("rw_fl", 0,0,0,0,0,1, 0,37,0,1,0,27,0));
    applyStimulus(mk("rw_a5", 1,0,0,0,0,0, 1,34,0,0,0,30,0));

    // Drain the list completely, then probe the empty case.
    doReset();
    for (int i = 0; i < 32; i++)
      applyStimulus(mk($sformatf("drain%0d", i), 1,0,0,0,0,0, 1,6'(32+i),0,0,0,6'(32-i),0));
    applyStimulus(mk("empty_req", 1,0,0,0,0,0, 0,32,0,0,0,0,0));
`ifdef FREELIST_BYPASS_EN
    applyStimulus(mk("bypass",      1,1,7,0,0,0, 1,7,0,0,0,0,0));
    applyStimulus(mk("bypass_post", 0,0,0,0,0,0, 0,32,0,0,0,0,0));
`else
    applyStimulus(mk("empty_free",  1,1,7,0,0,0, 0,32,0,0,0,0,0));
    applyStimulus(mk("refill",      1,0,0,0,0,0, 1,7,0,0,0,1,0));
    applyStimulus(mk("refill_post", 0,0,0,0,0,0, 0,33,0,0,0,0,0));
`endif

    // Overflow at full, alloc+free at full, then asynchronous reset mid-burst.
    doReset();
    applyStimulus(mk("ovf_free",  0,1,5,0,0,0, 0,32,0,0,0,32,0));
    applyStimulus(mk("ovf_set",   0,0,0,0,0,0, 0,32,0,0,0,32,1));
    applyStimulus(mk("full_swap", 1,1,20,0,0,0, 1,32,0,0,0,32,1));
    applyStimulus(mk("swap_post", 0,0,0,0,0,0, 0,33,0,0,0,32,1));
    applyStimulus(mk("burst0",    1,0,0,0,0,0, 1,33,0,0,0,32,1));
    applyStimulus(mk("burst1",    1,0,0,0,0,0, 1,34,0,0,0,31,1));
    alloc_req = 1; ckpt_req = 1;
    #2 rst_n = 1'b0;
    #1;
    sb_q.push_back(mk("async_rst", 1,0,0,1,0,0, 0,32,0,0,0,32,0));
    checkOutput();
    doReset();
    applyStimulus(mk("after_rst", 1,0,0,0,0,0, 1,32,0,0,0,32,0));

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/free_list_ctrl.md
FREE_LIST_CTRL -- requirements
Module: free_list_ctrl

Interface
REQ-001 Parameters, one per line:
- PHYS_REGS, 64, physical register count.
- ARCH_REGS, 32, architectural register count.
- CKPT_DEPTH, 4, branch checkpoint slots (power of 2).
REQ-002 Ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alloc_req  in  1  rename stage requests one destination physical register.
- alloc_gnt  out  1  request granted this cycle.
- alloc_preg  out  6  granted physical register index.
- free_valid  in  1  ROB commit releases a stale physical register.
- free_preg  in  6  released index.
- ckpt_req  in  1  branch renamed; snapshot free-list head.
- ckpt_ack  out  1  snapshot taken.
- ckpt_id  out  2  slot written on ckpt_ack.
- ckpt_full  out  1  all CKPT_DEPTH slots outstanding.
- ckpt_release  in  1  oldest branch resolved correct; retire oldest slot.
- flush  in  1  mispredict; restore from oldest slot.
- free_count  out  6  free entries, 0..32.
- ovf_err  out  1  sticky: release into full list.
REQ-003 One clock and one reset: clk, with rst_n asynchronous and active-low.

Function
REQ-004 Free list: circular FIFO, 32 entries x 6 bits; head/tail 6-bit pointers (5-bit index + wrap bit); free_count = tail - head mod 64.
REQ-005 Empty = (free_count == 0); full = (free_count == 32).
REQ-006 alloc_gnt = alloc_req & !empty (combinational from state); alloc_preg = fifo[head index]; head += 1 at edge when alloc_gnt.
REQ-007 free_valid & !full: fifo[tail index] <= free_preg; tail += 1.
REQ-008 alloc and free in same cycle: both take effect; free_count unchanged.
REQ-009 free_valid & full & !alloc_gnt: release dropped; ovf_err <= 1, held until reset.
REQ-010 Checkpoints: circular slots with wr/rd pointers and 3-bit occupancy; ckpt_full = (occupancy == CKPT_DEPTH).
REQ-011 ckpt_ack = ckpt_req & !ckpt_full & !flush; ckpt_id = wr pointer; slot stores head value after same-cycle allocation; wr pointer += 1.
REQ-012 ckpt_release with occupancy > 0: rd pointer += 1; with 0: ignored. ckpt_ack plus release in the same cycle: occupancy unchanged.
REQ-013 flush, occupancy > 0: head <= slot[rd pointer]; all slots invalidated (wr = rd = occupancy = 0); alloc and ckpt_req in that cycle ignored (alloc_gnt forced 0).
REQ-014 flush, occupancy == 0: head unchanged; slots cleared.
REQ-015 flush with free_valid: release still written at tail (commits are older than any branch).
REQ-016 Restoring head never loses entries: slots between restored head and old head are never overwritten by tail before flush.

Reset
REQ-017 While rst_n low: fifo[i] = 32 + i for i = 0..31; head = 0; tail = 32 (wrap set); free_count = 32.
REQ-018 While rst_n low: checkpoint pointers and occupancy 0; ckpt_full = 0; ovf_err = 0; alloc_gnt and ckpt_ack = 0.
REQ-019 Reset asserted mid-operation discards all state within the same cycle; no edge required.

Configuration
REQ-020 Macro FREELIST_BYPASS_EN. Defined: when empty, alloc_req and free_valid are all high and flush is low, alloc_gnt = 1 and alloc_preg = free_preg. In that case the FIFO is not written and head/tail are unchanged. Undefined: alloc_gnt = 0 when empty, and the release is written normally.

Verification
REQ-021 Reset then 3 alloc_req cycles -> alloc_preg 32, 33, 34; free_count 29.
REQ-022 32 allocs -> free_count 0; then alloc_req -> alloc_gnt 0. With FREELIST_BYPASS_EN, alloc_req + free_valid(preg 7) -> alloc_gnt 1, alloc_preg 7, free_count stays 0.
REQ-023 Sequence:
- alloc 2 (32, 33), then ckpt_req -> ckpt_ack 1, ckpt_id 0.
- alloc 3 (34, 35, 36), then flush.
- Next alloc_preg = 34; free_count 30.
REQ-024 4 ckpt_req -> ckpt_full 1; 5th ckpt_req -> ckpt_ack 0. ckpt_release -> ckpt_full 0; next ckpt_req -> ckpt_id 0.
REQ-025 At reset, free_valid (preg 5) -> ovf_err 1 and free_count stays 32. Assert rst_n low mid-burst -> outputs at REQ-017/018 values immediately.
